// File: rtl/esfa_trace_pkg.sv
// Shared record layout, FSM encoding and record builder for the ESFA trace recorder.
// The record layout is the 40-bit test-vector format replayed by the ESFA benchmark.
package esfa_trace_pkg;

  localparam int REC_W = 40;

  localparam int BIT_MUT  = 0;
  localparam int BIT_EXP  = 1;
  localparam int BIT_END  = 2;
  localparam int BIT_META = 3;

  localparam int LSB_INDEX = 8;
  localparam int LSB_VALUE = 16;
  localparam int LSB_META  = 24;
  localparam int LSB_SEL   = 32;

  localparam logic [REC_W-1:0] END_RECORD = REC_W'(1) << BIT_END;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECORD,
    ST_DRAIN,
    ST_WRITE_END,
    ST_DONE
  } state_t;

  // The expected-result bit is left clear here; it is merged once resultBool is known.
  function automatic logic [REC_W-1:0] build_record(
    input logic       isMut,
    input logic       isMeta,
    input logic [7:0] idx,
    input logic [7:0] val,
    input logic [7:0] md,
    input logic [7:0] sel
  );
    logic [REC_W-1:0] rec;
    rec                    = '0;
    rec[BIT_MUT]           = isMut;
    rec[BIT_META]          = isMeta;
    rec[LSB_INDEX +: 8]    = idx;
    rec[LSB_VALUE +: 8]    = val;
    rec[LSB_META  +: 8]    = md;
    rec[LSB_SEL   +: 8]    = sel;
    return rec;
  endfunction

endpackage

// File: rtl/esfa_result_align.sv
// Delay line that holds each accepted record until its resultBool arrives, then
// presents the completed record as a registered write one cycle later.
module esfa_result_align
  import esfa_trace_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [REC_W-1:0] i_record,
  input  logic             i_result_bool,
  output logic             o_valid,
  output logic [REC_W-1:0] o_record,
  output logic             o_busy
);

  logic [LATENCY-1:0] r_vld;
  logic [REC_W-1:0]   r_rec [LATENCY];
  logic               r_outVld;
  logic [REC_W-1:0]   r_outRec;

  // The last stage is sampled on the edge where resultBool becomes valid; mutating ops never carry a result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld    <= '0;
      for (int i = 0; i < LATENCY; i++) r_rec[i] <= '0;
      r_outVld <= 1'b0;
      r_outRec <= '0;
    end else begin
      r_vld[0] <= i_valid;
      r_rec[0] <= i_record;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_rec[i] <= r_rec[i-1];
      end
      r_outVld          <= r_vld[LATENCY-1];
      r_outRec          <= r_rec[LATENCY-1];
      r_outRec[BIT_EXP] <= i_result_bool & ~r_rec[LATENCY-1][BIT_MUT];
    end
  end

  assign o_valid  = r_outVld;
  assign o_record = r_outRec;
  assign o_busy   = (|r_vld) | r_outVld;

endmodule

// File: rtl/esfa_trace_recorder.sv
// Captures the live ESFA op stream plus resultBool into a BRAM as a replayable
// golden program, closed by an end-of-program record.
module esfa_trace_recorder
  import esfa_trace_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = 8,
  parameter int RESULT_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              finish,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_is_mutating,
  input  logic              op_is_metadata,
  input  logic [7:0]        new_index,
  input  logic [7:0]        new_value,
  input  logic [7:0]        metadata,
  input  logic [7:0]        selector,
  input  logic              result_bool,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [REC_W-1:0]  mem_wdata,
  output logic              recording,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   record_count
);

  // The top slot is kept free so the end record always fits.
  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [ADDR_W:0]  r_accCount;
  logic [ADDR_W:0]  r_count;
  logic             r_overflow;
  logic             w_accept;
  logic             w_drop;
  logic             w_startCapture;
  logic             w_endWrite;
  logic             w_alignVld;
  logic             w_alignBusy;
  logic [REC_W-1:0] w_alignRec;
  logic [REC_W-1:0] w_opRecord;

  assign w_opRecord = build_record(op_is_mutating, op_is_metadata, new_index,
                                   new_value, metadata, selector);
  assign w_accept   = op_valid && op_ready;
  assign w_drop     = (r_state == ST_RECORD) && op_valid && !op_ready;

  esfa_result_align #(
    .LATENCY(RESULT_LATENCY)
  ) u_align (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (w_accept),
    .i_record     (w_opRecord),
    .i_result_bool(result_bool),
    .o_valid      (w_alignVld),
    .o_record     (w_alignRec),
    .o_busy       (w_alignBusy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (arm) w_nextState = ST_RECORD;
      ST_RECORD:        if (finish || w_drop) w_nextState = ST_DRAIN;
      ST_DRAIN:         if (!w_alignBusy) w_nextState = ST_WRITE_END;
      ST_WRITE_END:     w_nextState = ST_DONE;
      default:          w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    recording      = (r_state == ST_RECORD);
    done           = (r_state == ST_DONE);
    w_endWrite     = (r_state == ST_WRITE_END);
    w_startCapture = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && arm;
    op_ready       = (r_state == ST_RECORD) && (r_accCount < LAST_SLOT);
  end

  // Write slots follow write order, which equals accept order since the delay line never reorders.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_accCount <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_startCapture) begin
      r_accCount <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_accCount <= r_accCount + 1'b1;
      if (mem_we)   r_count    <= r_count + 1'b1;
      if (w_drop)   r_overflow <= 1'b1;
    end
  end

  assign mem_we       = w_alignVld | w_endWrite;
  assign mem_addr     = r_count[ADDR_W-1:0];
  assign mem_wdata    = w_endWrite ? END_RECORD : (w_alignVld ? w_alignRec : '0);
  assign overflow     = r_overflow;
  assign record_count = r_count;

endmodule

// File: tb/tb_esfa_trace_recorder.sv
// Directed bench for esfa_trace_recorder: three instances (default, latency 3, depth 4)
// share one op stream; each scenario task checks the instance it targets.
module tb_esfa_trace_recorder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       arm = 1'b0;
  logic       finish = 1'b0;
  logic       opValid = 1'b0;
  logic       opMut = 1'b0;
  logic       opMeta = 1'b0;
  logic [7:0] opIdx = '0;
  logic [7:0] opVal = '0;
  logic [7:0] opMd = '0;
  logic [7:0] opSel = '0;
  logic       rbWant = 1'b0;
  logic [2:0] rbShift = '0;
  wire        rbL1 = rbShift[0];
  wire        rbL3 = rbShift[2];

  logic        d0Ready, d0We, d0Rec, d0Done, d0Ovf;
  logic [7:0]  d0Addr;
  logic [39:0] d0Wdata;
  logic [8:0]  d0Cnt;
  logic        d3Ready, d3We, d3Rec, d3Done, d3Ovf;
  logic [7:0]  d3Addr;
  logic [39:0] d3Wdata;
  logic [8:0]  d3Cnt;
  logic        d4Ready, d4We, d4Rec, d4Done, d4Ovf;
  logic [1:0]  d4Addr;
  logic [39:0] d4Wdata;
  logic [2:0]  d4Cnt;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleCnt = 0;
  logic [47:0] wq0[$];
  logic [47:0] wq3[$];
  logic [47:0] wq4[$];
  int cq0[$];
  int cq3[$];

  esfa_trace_recorder #(.DEPTH(256), .ADDR_W(8), .RESULT_LATENCY(1)) dut0 (
    .clk(clk), .reset(reset), .arm(arm), .finish(finish), .op_valid(opValid), .op_ready(d0Ready),
    .op_is_mutating(opMut), .op_is_metadata(opMeta), .new_index(opIdx), .new_value(opVal),
    .metadata(opMd), .selector(opSel), .result_bool(rbL1), .mem_we(d0We), .mem_addr(d0Addr),
    .mem_wdata(d0Wdata), .recording(d0Rec), .done(d0Done), .overflow(d0Ovf), .record_count(d0Cnt));

  esfa_trace_recorder #(.DEPTH(256), .ADDR_W(8), .RESULT_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .arm(arm), .finish(finish), .op_valid(opValid), .op_ready(d3Ready),
    .op_is_mutating(opMut), .op_is_metadata(opMeta), .new_index(opIdx), .new_value(opVal),
    .metadata(opMd), .selector(opSel), .result_bool(rbL3), .mem_we(d3We), .mem_addr(d3Addr),
    .mem_wdata(d3Wdata), .recording(d3Rec), .done(d3Done), .overflow(d3Ovf), .record_count(d3Cnt));

  esfa_trace_recorder #(.DEPTH(4), .ADDR_W(2), .RESULT_LATENCY(1)) dut4 (
    .clk(clk), .reset(reset), .arm(arm), .finish(finish), .op_valid(opValid), .op_ready(d4Ready),
    .op_is_mutating(opMut), .op_is_metadata(opMeta), .new_index(opIdx), .new_value(opVal),
    .metadata(opMd), .selector(opSel), .result_bool(rbL1), .mem_we(d4We), .mem_addr(d4Addr),
    .mem_wdata(d4Wdata), .recording(d4Rec), .done(d4Done), .overflow(d4Ovf), .record_count(d4Cnt));

  always #5 clk = ~clk;

  // Stand-in for ESFADesign: the wanted result of an accepted op reaches result_bool after the latency.
  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    rbShift  <= {rbShift[1:0], rbWant};
  end

  always @(negedge clk) begin
    if (d0We === 1'b1) begin wq0.push_back({d0Addr, d0Wdata}); cq0.push_back(cycleCnt); end
    if (d3We === 1'b1) begin wq3.push_back({d3Addr, d3Wdata}); cq3.push_back(cycleCnt); end
    if (d4We === 1'b1) wq4.push_back({6'b0, d4Addr, d4Wdata});
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idleInputs();
    arm = 0; finish = 0; opValid = 0; opMut = 0; opMeta = 0;
    opIdx = 0; opVal = 0; opMd = 0; opSel = 0; rbWant = 0;
  endtask

  task automatic setOp(input logic mut, input logic meta, input logic [7:0] idx, input logic [7:0] val,
                       input logic [7:0] md, input logic [7:0] sel, input logic rb);
    opValid = 1; opMut = mut; opMeta = meta; opIdx = idx; opVal = val; opMd = md; opSel = sel; rbWant = rb;
  endtask

  task automatic clearQueues();
    wq0.delete(); wq3.delete(); wq4.delete(); cq0.delete(); cq3.delete();
  endtask

  task automatic pulseReset();
    reset = 0; cyc(2); reset = 1; cyc(1);
  endtask

  function automatic logic pickDone(input int which);
    case (which)
      0:       return d0Done;
      3:       return d3Done;
      default: return d4Done;
    endcase
  endfunction

  task automatic waitDone(input int which, input string name);
    int n;
    logic d;
    n = 0;
    d = pickDone(which);
    while (d !== 1'b1 && n < 100) begin cyc(1); n++; d = pickDone(which); end
    testsRun++;
    if (d !== 1'b1) begin testsFailed++; $display("[TB] FAIL %s got done=%b want 1 within 100 cycles", name, d); end
    cyc(2);
  endtask

  task automatic test_reset();
    #2 reset = 0;
    #1;
    testsRun++; if (d0We !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_we got %b want 0", d0We); end
    testsRun++; if (d0Addr !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_addr got %h want 0", d0Addr); end
    testsRun++; if (d0Wdata !== 40'd0) begin testsFailed++; $display("[TB] FAIL reset_wdata got %h want 0", d0Wdata); end
    testsRun++; if (d0Cnt !== 9'd0) begin testsFailed++; $display("[TB] FAIL reset_count got %0d want 0", d0Cnt); end
    testsRun++;
    if ({d0Rec, d0Done, d0Ovf, d0Ready} !== 4'b0000) begin
      testsFailed++; $display("[TB] FAIL reset_status got %b want 0000", {d0Rec, d0Done, d0Ovf, d0Ready});
    end
    cyc(2); reset = 1; cyc(1);
  endtask

  task automatic test_basic();
    logic [47:0] exp [4];
    logic [47:0] got;
    int acc;
    exp[0] = {8'd0, 40'h0000050101};
    exp[1] = {8'd1, 40'h0200000002};
    exp[2] = {8'd2, 40'h0300000000};
    exp[3] = {8'd3, 40'h0000000004};
    clearQueues();
    arm = 1; cyc(1); arm = 0;
    testsRun++; if ({d0Rec, d0Ready} !== 2'b11) begin testsFailed++; $display("[TB] FAIL basic_armed got rec/ready=%b want 11", {d0Rec, d0Ready}); end
    acc = cycleCnt;
    setOp(1, 0, 8'd1, 8'd5, 8'd0, 8'd0, 0); cyc(1);
    setOp(0, 0, 8'd0, 8'd0, 8'd0, 8'd2, 1); cyc(1);
    setOp(0, 0, 8'd0, 8'd0, 8'd0, 8'd3, 0); cyc(1);
    idleInputs(); finish = 1; cyc(1); finish = 0;
    waitDone(0, "basic_done");
    testsRun++; if (wq0.size() != 4) begin testsFailed++; $display("[TB] FAIL basic_nwrites got %0d want 4", wq0.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < wq0.size()) ? wq0[i] : 48'hx;
      testsRun++; if (got !== exp[i]) begin testsFailed++; $display("[TB] FAIL basic_write%0d got %h want %h", i, got, exp[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if (i >= cq0.size() || cq0[i] != acc + 2 + i) begin
        testsFailed++; $display("[TB] FAIL basic_write%0d_cycle got %0d want %0d", i, (i < cq0.size()) ? cq0[i] : -1, acc + 2 + i);
      end
    end
    testsRun++; if (d0Cnt !== 9'd4) begin testsFailed++; $display("[TB] FAIL basic_count got %0d want 4", d0Cnt); end
    testsRun++; if ({d0Done, d0Rec, d0Ovf} !== 3'b100) begin testsFailed++; $display("[TB] FAIL basic_status got %b want 100", {d0Done, d0Rec, d0Ovf}); end
  endtask

  task automatic test_latency3_finish();
    logic [47:0] exp [3];
    logic [47:0] got;
    int acc;
    exp[0] = {8'd0, 40'h0500000000};
    exp[1] = {8'd1, 40'h06AA00000A};
    exp[2] = {8'd2, 40'h0000000004};
    pulseReset(); clearQueues();
    arm = 1; cyc(1); arm = 0;
    acc = cycleCnt;
    setOp(0, 0, 8'd0, 8'd0, 8'd0, 8'd5, 0); cyc(1);
    setOp(0, 1, 8'd0, 8'd0, 8'hAA, 8'd6, 1); finish = 1; cyc(1);
    idleInputs();
    waitDone(3, "lat3_done");
    testsRun++; if (wq3.size() != 3) begin testsFailed++; $display("[TB] FAIL lat3_nwrites got %0d want 3", wq3.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < wq3.size()) ? wq3[i] : 48'hx;
      testsRun++; if (got !== exp[i]) begin testsFailed++; $display("[TB] FAIL lat3_write%0d got %h want %h", i, got, exp[i]); end
    end
    testsRun++;
    if (cq3.size() == 0 || cq3[0] != acc + 4) begin
      testsFailed++; $display("[TB] FAIL lat3_first_cycle got %0d want %0d", (cq3.size() > 0) ? cq3[0] : -1, acc + 4);
    end
    testsRun++; if (d3Cnt !== 9'd3) begin testsFailed++; $display("[TB] FAIL lat3_count got %0d want 3", d3Cnt); end
  endtask

  task automatic test_overflow();
    logic [47:0] exp [4];
    logic [47:0] got;
    exp[0] = {8'd0, 40'h0100000000};
    exp[1] = {8'd1, 40'h0200000000};
    exp[2] = {8'd2, 40'h0300000000};
    exp[3] = {8'd3, 40'h0000000004};
    pulseReset(); clearQueues();
    arm = 1; cyc(1); arm = 0;
    for (int i = 0; i < 5; i++) begin
      testsRun++;
      if (d4Ready !== (i < 3)) begin testsFailed++; $display("[TB] FAIL ovf_ready%0d got %b want %b", i, d4Ready, (i < 3)); end
      setOp(0, 0, 8'd0, 8'd0, 8'd0, 8'(i + 1), 0); cyc(1);
    end
    idleInputs();
    testsRun++; if ({d4Ovf, d4Rec} !== 2'b10) begin testsFailed++; $display("[TB] FAIL ovf_flag got ovf/rec=%b want 10", {d4Ovf, d4Rec}); end
    waitDone(4, "ovf_done");
    testsRun++; if (wq4.size() != 4) begin testsFailed++; $display("[TB] FAIL ovf_nwrites got %0d want 4", wq4.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < wq4.size()) ? wq4[i] : 48'hx;
      testsRun++; if (got !== exp[i]) begin testsFailed++; $display("[TB] FAIL ovf_write%0d got %h want %h", i, got, exp[i]); end
    end
    testsRun++; if ({d4Cnt, d4Ovf} !== {3'd4, 1'b1}) begin testsFailed++; $display("[TB] FAIL ovf_final got count=%0d ovf=%b want 4/1", d4Cnt, d4Ovf); end
  endtask

  task automatic test_ignored_in_done();
    wq4.delete();
    setOp(0, 0, 8'd0, 8'd0, 8'd0, 8'h77, 0); cyc(3);
    idleInputs(); cyc(2);
    testsRun++; if (wq4.size() != 0) begin testsFailed++; $display("[TB] FAIL done_op_writes got %0d want 0", wq4.size()); end
    testsRun++;
    if ({d4Done, d4Ready, d4Cnt} !== {1'b1, 1'b0, 3'd4}) begin
      testsFailed++; $display("[TB] FAIL done_op_state got done=%b ready=%b count=%0d want 1/0/4", d4Done, d4Ready, d4Cnt);
    end
    arm = 1; cyc(1); arm = 0;
    testsRun++;
    if ({d4Rec, d4Done, d4Ovf, d4Cnt} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      testsFailed++; $display("[TB] FAIL rearm got rec=%b done=%b ovf=%b count=%0d want 1/0/0/0", d4Rec, d4Done, d4Ovf, d4Cnt);
    end
  endtask

  task automatic test_idle_finish();
    pulseReset(); clearQueues();
    finish = 1; cyc(1); finish = 0; cyc(3);
    testsRun++; if (wq0.size() != 0) begin testsFailed++; $display("[TB] FAIL idle_finish_writes got %0d want 0", wq0.size()); end
    testsRun++; if ({d0Rec, d0Done} !== 2'b00) begin testsFailed++; $display("[TB] FAIL idle_finish_state got rec/done=%b want 00", {d0Rec, d0Done}); end
  endtask

  task automatic test_async_reset();
    logic [47:0] got;
    pulseReset(); clearQueues();
    arm = 1; cyc(1); arm = 0;
    setOp(1, 0, 8'd9, 8'd9, 8'd0, 8'd0, 0); cyc(1);
    setOp(0, 0, 8'd0, 8'd0, 8'd0, 8'd4, 1); cyc(1);
    idleInputs();
    testsRun++; if (d0We !== 1'b1) begin testsFailed++; $display("[TB] FAIL arst_inflight got we=%b want 1", d0We); end
    #2 reset = 0;
    #1;
    testsRun++;
    if ({d0We, d0Rec, d0Cnt, d0Wdata} !== {1'b0, 1'b0, 9'd0, 40'd0}) begin
      testsFailed++; $display("[TB] FAIL arst_outputs got we=%b rec=%b count=%0d wdata=%h want 0", d0We, d0Rec, d0Cnt, d0Wdata);
    end
    cyc(2); clearQueues(); reset = 1; cyc(6);
    testsRun++; if (wq0.size() != 0) begin testsFailed++; $display("[TB] FAIL arst_no_write got %0d writes want 0", wq0.size()); end
    arm = 1; cyc(1); arm = 0;
    setOp(0, 0, 8'd0, 8'd0, 8'd0, 8'd8, 1); cyc(1);
    idleInputs(); finish = 1; cyc(1); finish = 0;
    waitDone(0, "arst_restart_done");
    got = (wq0.size() > 0) ? wq0[0] : 48'hx;
    testsRun++; if (got !== {8'd0, 40'h0800000002}) begin testsFailed++; $display("[TB] FAIL arst_restart_w0 got %h want %h", got, {8'd0, 40'h0800000002}); end
    got = (wq0.size() > 1) ? wq0[1] : 48'hx;
    testsRun++; if (got !== {8'd1, 40'h0000000004}) begin testsFailed++; $display("[TB] FAIL arst_restart_w1 got %h want %h", got, {8'd1, 40'h0000000004}); end
    testsRun++; if (d0Cnt !== 9'd2) begin testsFailed++; $display("[TB] FAIL arst_restart_count got %0d want 2", d0Cnt); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idleInputs();
    test_reset();
    test_basic();
    test_latency3_finish();
    test_overflow();
    test_ignored_in_done();
    test_idle_finish();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
